spi_slave_regs: RTL and testbench

SPI responder for the team's 2-byte SPI master frame: address byte, then data byte, CSN low, SCLK idle high.
- MOSI changes on SCLK fall and is sampled on SCLK rise.
- Exposes a 16 x 8 register bank that the SPI side can write or read back.
- A local host port gives access to the same bank.
- All logic runs on i_ck. SCLK, CSN and MOSI are oversampled, never used as clocks.

---
 rtl/spi_slave_regs.sv | 216 +++++++++++++++++++++
 tb/tb_spi_slave_regs.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regs.sv
// SPI responder with a 16 x 8 register bank shared with a local host port.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first bytes; MSB-first otherwise.
module spi_slave_regs #(
    parameter int SYNC_STAGES = 2,
    parameter int NREGS       = 16
) (
    input  logic       i_ck,
    input  logic       i_rstn,
    input  logic       i_sclk,
    input  logic       i_csn,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_miso_oe,
    input  logic [3:0] i_address,
    input  logic [7:0] i_data,
    input  logic       i_wr,
    input  logic       i_rd,
    output logic [7:0] o_data,
    output logic       o_rx_valid,
    output logic [3:0] o_rx_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_q;
    logic                   csn_q;

    logic sclk_s;
    logic csn_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic csn_rise;
    logic csn_fall;

    logic [2:0] bit_cnt;
    logic [7:0] rx_sh;
    logic [7:0] rx_next;
    logic [7:0] tx_sh;
    logic [7:0] tx_shifted;
    logic       tx_bit;
    logic       wr_frame;
    logic [3:0] idx;
    logic       last_bit;
    logic       addr_done;
    logic       commit;
    logic       in_frame;

    logic [7:0] bank [NREGS];
    logic [7:0] host_rd_word;
    logic [7:0] spi_rd_word;

    // SCLK/CSN reset to their idle-high level so reset release is not an edge
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            sclk_sync <= '1;
            csn_sync  <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b1;
            csn_q     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], i_csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            sclk_q    <= sclk_s;
            csn_q     <= csn_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign csn_rise  = csn_s & ~csn_q;
    assign csn_fall  = ~csn_s & csn_q;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_next    = {mosi_s, rx_sh[7:1]};
    assign tx_bit     = tx_sh[0];
    assign tx_shifted = {1'b0, tx_sh[7:1]};
`else
    assign rx_next    = {rx_sh[6:0], mosi_s};
    assign tx_bit     = tx_sh[7];
    assign tx_shifted = {tx_sh[6:0], 1'b0};
`endif

    assign last_bit = sclk_rise & (bit_cnt == 3'd7);
    assign in_frame = (state_q == S_ADDR) | (state_q == S_DATA);

    assign host_rd_word = (int'(i_address) < NREGS) ? bank[i_address] : 8'h00;
    assign spi_rd_word  = (int'(rx_next[3:0]) < NREGS) ? bank[rx_next[3:0]] : 8'h00;

    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An abort (CSN rise) wins over a coincident final SCLK rise
    always_comb begin
        state_d   = state_q;
        addr_done = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (csn_fall) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (csn_rise) begin
                    state_d = S_IDLE;
                end else if (last_bit) begin
                    state_d   = S_DATA;
                    addr_done = 1'b1;
                end
            end
            S_DATA: begin
                if (csn_rise) begin
                    state_d = S_IDLE;
                end else if (last_bit) begin
                    state_d = S_DONE;
                    commit  = wr_frame;
                end
            end
            S_DONE: begin
                if (csn_rise) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            bit_cnt  <= 3'd0;
            rx_sh    <= 8'h00;
            tx_sh    <= 8'h00;
            wr_frame <= 1'b0;
            idx      <= 4'd0;
        end else begin
            if ((state_q == S_IDLE) && csn_fall) begin
                bit_cnt <= 3'd0;
            end else if (in_frame && sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sh   <= rx_next;
            end
            // Read data is snapshotted here; later bank writes do not reach it
            if (addr_done) begin
                wr_frame <= rx_next[7];
                idx      <= rx_next[3:0];
                tx_sh    <= rx_next[7] ? 8'h00 : spi_rd_word;
            end else if ((state_q == S_DATA) && !wr_frame && sclk_fall) begin
                tx_sh <= tx_shifted;
            end
        end
    end

    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            o_miso     <= 1'b0;
            o_miso_oe  <= 1'b0;
            o_rx_valid <= 1'b0;
            o_rx_addr  <= 4'd0;
        end else begin
            o_miso_oe  <= ~csn_s;
            o_rx_valid <= commit;
            if (commit) begin
                o_rx_addr <= idx;
            end
            if ((state_q != S_DATA) || wr_frame) begin
                o_miso <= 1'b0;
            end else if (sclk_fall) begin
                o_miso <= tx_bit;
            end
        end
    end

    // The SPI commit is assigned last so it wins a same-register collision
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                bank[i] <= 8'h00;
            end
            o_data <= 8'h00;
        end else begin
            if (i_wr && (int'(i_address) < NREGS)) begin
                bank[i_address] <= i_data;
            end
            if (commit && (int'(idx) < NREGS)) begin
                bank[idx] <= rx_next;
            end
            if (i_rd) begin
                o_data <= host_rd_word;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: directed and random SPI frames against a bank model.
// Bit order follows SPI_SLAVE_LSB_FIRST_EN, matching the DUT build.
module tb_spi_slave_regs;

    logic       ck;
    logic       rstn;
    logic       sclk;
    logic       csn;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [3:0] address;
    logic [7:0] wdata;
    logic       wr;
    logic       rd;
    logic [7:0] rdata;
    logic       rx_valid;
    logic [3:0] rx_addr;

    int checks = 0;
    int errors = 0;
    int rx_pulses = 0;
    logic [7:0] bank_m [16];

`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    spi_slave_regs dut (
        .i_ck      (ck),
        .i_rstn    (rstn),
        .i_sclk    (sclk),
        .i_csn     (csn),
        .i_mosi    (mosi),
        .o_miso    (miso),
        .o_miso_oe (miso_oe),
        .i_address (address),
        .i_data    (wdata),
        .i_wr      (wr),
        .i_rd      (rd),
        .o_data    (rdata),
        .o_rx_valid(rx_valid),
        .o_rx_addr (rx_addr)
    );

    initial ck = 1'b0;
    always #25 ck = ~ck;

    always @(negedge ck) begin
        if (rx_valid === 1'b1) rx_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_op(input logic [3:0] a, input logic [7:0] d,
                           input bit w, input bit r);
        address = a;
        wdata   = d;
        wr      = w;
        rd      = r;
        @(negedge ck);
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic chk_reg(input logic [3:0] a);
        host_op(a, 8'h00, 1'b0, 1'b1);
        chk("host_rd", rdata, bank_m[a]);
    endtask

    // Master side: SCLK half period is 10 i_ck cycles, toggles on negedges
    task automatic spi_frame(input logic [7:0] a, input logic [7:0] d,
                             input int ndata, input bit collide,
                             input bit snap, input logic [7:0] hw_d,
                             output logic [7:0] rb);
        int nb;
        rb = 8'h00;
        nb = 8 + ndata;
        csn = 1'b0;
        repeat (10) @(negedge ck);
        chk("oe_in_frame", miso_oe, 1);
        for (int k = 0; k < nb; k++) begin
            int j;
            int bi;
            j  = k % 8;
            bi = LSB ? j : 7 - j;
            sclk = 1'b0;
            mosi = (k < 8) ? a[bi] : d[bi];
            if (snap && k == 8) begin
                repeat (5) @(negedge ck);
                host_op(a[3:0], hw_d, 1'b1, 1'b0);
                repeat (4) @(negedge ck);
            end else begin
                repeat (10) @(negedge ck);
            end
            sclk = 1'b1;
            if (k >= 8) rb[bi] = miso;
            if (k < 8 || a[7]) chk("miso_quiet", miso, 0);
            // Commit lands SYNC_STAGES+1 = 3 posedges after the pin edge
            if (collide && k == 15) begin
                repeat (2) @(negedge ck);
                host_op(a[3:0], hw_d, 1'b1, 1'b0);
                repeat (7) @(negedge ck);
            end else begin
                repeat (10) @(negedge ck);
            end
        end
        csn = 1'b1;
        repeat (10) @(negedge ck);
        chk("oe_idle", miso_oe, 0);
    endtask

    task automatic do_frame(input logic [7:0] a, input logic [7:0] d,
                            input int ndata, input bit collide,
                            input bit snap, input logic [7:0] hw_d);
        logic [7:0] rb;
        logic [7:0] exp_rb;
        logic [3:0] ix;
        int p0;
        ix     = a[3:0];
        exp_rb = bank_m[ix];
        p0     = rx_pulses;
        spi_frame(a, d, ndata, collide, snap, hw_d, rb);
        if (snap || collide) bank_m[ix] = hw_d;
        if (a[7] && ndata == 8) begin
            bank_m[ix] = d;
            chk("rx_pulse", rx_pulses - p0, 1);
            chk("rx_addr", rx_addr, ix);
        end else begin
            chk("rx_pulse_none", rx_pulses - p0, 0);
        end
        if (!a[7] && ndata == 8) chk("miso_byte", rb, exp_rb);
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_miso"}, miso, 0);
        chk({tag, "_oe"}, miso_oe, 0);
        chk({tag, "_data"}, rdata, 0);
        chk({tag, "_rxv"}, rx_valid, 0);
        chk({tag, "_rxa"}, rx_addr, 0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rd8;
        int nd;
        rstn = 1'b0;
        sclk = 1'b1;
        csn = 1'b1;
        mosi = 1'b0;
        address = 4'd0;
        wdata = 8'h00;
        wr = 1'b0;
        rd = 1'b0;
        for (int i = 0; i < 16; i++) bank_m[i] = 8'h00;
        repeat (3) @(negedge ck);
        chk_outputs_reset("rst");
        rstn = 1'b1;
        repeat (5) @(negedge ck);

        do_frame(8'h85, 8'h5A, 8, 1'b0, 1'b0, 8'h00);
        chk_reg(4'd5);

        host_op(4'd3, 8'hC3, 1'b1, 1'b0);
        bank_m[3] = 8'hC3;
        do_frame(8'h03, 8'h00, 8, 1'b0, 1'b0, 8'h00);

        do_frame(8'h81, 8'hFF, 4, 1'b0, 1'b0, 8'h00);
        chk_reg(4'd1);
        do_frame(8'h81, 8'h11, 8, 1'b0, 1'b0, 8'h00);
        chk_reg(4'd1);

        do_frame(8'h87, 8'h77, 8, 1'b1, 1'b0, 8'h22);
        chk_reg(4'd7);

        host_op(4'd7, 8'h99, 1'b1, 1'b1);
        chk("wr_rd_old", rdata, 8'h77);
        bank_m[7] = 8'h99;
        chk_reg(4'd7);

        do_frame(8'h05, 8'h00, 8, 1'b0, 1'b1, 8'hEE);
        chk_reg(4'd5);

        do_frame(8'h82, 8'h3C, 8, 1'b0, 1'b0, 8'h00);
        chk_reg(4'd2);

        for (int n = 0; n < 10; n++) begin
            ra  = 8'($urandom);
            rd8 = 8'($urandom);
            nd  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : 8;
            if ($urandom_range(0, 1) == 1) begin
                host_op(ra[3:0] ^ 4'd1, rd8 ^ 8'h5A, 1'b1, 1'b0);
                bank_m[ra[3:0] ^ 4'd1] = rd8 ^ 8'h5A;
            end
            do_frame(ra, rd8, nd, 1'b0, 1'b0, 8'h00);
            chk_reg(ra[3:0]);
        end

        host_op(4'd4, 8'hA5, 1'b1, 1'b0);
        bank_m[4] = 8'hA5;
        chk_reg(4'd4);
        csn = 1'b0;
        repeat (10) @(negedge ck);
        for (int k = 0; k < 4; k++) begin
            sclk = 1'b0;
            mosi = k[0];
            repeat (10) @(negedge ck);
            sclk = 1'b1;
            repeat (10) @(negedge ck);
        end
        rstn = 1'b0;
        @(negedge ck);
        chk_outputs_reset("midrst");
        csn = 1'b1;
        sclk = 1'b1;
        repeat (3) @(negedge ck);
        rstn = 1'b1;
        repeat (5) @(negedge ck);
        for (int i = 0; i < 16; i++) bank_m[i] = 8'h00;
        for (int i = 0; i < 16; i++) chk_reg(4'(i));

        do_frame(8'hC9, 8'h42, 8, 1'b0, 1'b0, 8'h00);
        chk_reg(4'd9);
        do_frame(8'h39, 8'h00, 8, 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
